// File: rtl/peripheral_spram_ahb3_ws.sv
// rtl/peripheral_spram_ahb3_ws.sv - AHB3-Lite single-port SRAM slave with configurable wait states
// Byte-lane writes commit in the last data-phase cycle; read-after-write to the same word is forwarded or stalled.
module peripheral_spram_ahb3_ws #(
    parameter int MEM_DEPTH   = 256,
    parameter int PLEN        = 32,
    parameter int XLEN        = 32,
    parameter int WAIT_STATES = 0,
    parameter int RAW_FORWARD = 1
) (
    input  logic            HCLK,
    input  logic            HRESETn,
    input  logic            HSEL,
    input  logic [PLEN-1:0] HADDR,
    input  logic [XLEN-1:0] HWDATA,
    output logic [XLEN-1:0] HRDATA,
    input  logic            HWRITE,
    input  logic [2:0]      HSIZE,
    input  logic [2:0]      HBURST,
    input  logic [3:0]      HPROT,
    input  logic [1:0]      HTRANS,
    input  logic            HMASTLOCK,
    input  logic            HREADY,
    output logic            HREADYOUT,
    output logic            HRESP
);

    localparam int BW        = XLEN / 8;
    localparam int AW        = $clog2(BW);
    localparam int IW        = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int MEM_BYTES = MEM_DEPTH * BW;
    localparam int CW        = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_OKAY,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t          state;
    logic [XLEN-1:0] mem [MEM_DEPTH];
    logic [CW-1:0]   wait_cnt;
    logic            pend_write;
    logic [IW-1:0]   pend_idx;
    logic [BW-1:0]   pend_be;

    logic            accept;
    logic            req_err;
    logic            raw_hit;
    logic [BW-1:0]   req_be;
    logic [IW-1:0]   req_idx;
    logic [CW-1:0]   req_waits;
    logic [XLEN-1:0] rd_word;
    logic            unused_ok;

    assign unused_ok = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};

    // HREADYOUT gating keeps WAIT/ERR1 from re-accepting if HREADY is not wired back from us
    assign accept  = HSEL & HREADY & HTRANS[1] & HREADYOUT;
    assign req_idx = HADDR[AW +: IW];

    always_comb begin
        int lo;
        int nbytes;
        lo      = 32'(HADDR[AW-1:0]);
        nbytes  = 32'd1 << HSIZE;
        req_err = 1'b0;
        if ({1'b0, HADDR} >= (PLEN+1)'(MEM_BYTES))
            req_err = 1'b1;
        if (32'(HSIZE) > AW)
            req_err = 1'b1;
        else if ((lo & (nbytes - 1)) != 0)
            req_err = 1'b1;
        for (int i = 0; i < BW; i++)
            req_be[i] = (i >= lo) && (i < lo + nbytes);
    end

    // A read accepted while a write to the same word finishes its data phase
    assign raw_hit = (state == ST_OKAY) && pend_write && !HWRITE && (req_idx == pend_idx);

    always_comb begin
        rd_word = mem[req_idx];
        if (RAW_FORWARD != 0 && raw_hit) begin
            for (int b = 0; b < BW; b++)
                if (pend_be[b])
                    rd_word[8*b +: 8] = HWDATA[8*b +: 8];
        end
        req_waits = CW'(WAIT_STATES);
        if (RAW_FORWARD == 0 && raw_hit)
            req_waits = CW'(WAIT_STATES) + 1'b1;
    end

    always_ff @(posedge HCLK) begin
        if (HRESETn && state == ST_OKAY && pend_write) begin
            for (int b = 0; b < BW; b++)
                if (pend_be[b])
                    mem[pend_idx][8*b +: 8] <= HWDATA[8*b +: 8];
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state      <= ST_IDLE;
            HREADYOUT  <= 1'b1;
            HRESP      <= 1'b0;
            HRDATA     <= '0;
            wait_cnt   <= '0;
            pend_write <= 1'b0;
            pend_idx   <= '0;
            pend_be    <= '0;
        end else begin
            case (state)
                ST_WAIT: begin
                    if (wait_cnt <= CW'(1)) begin
                        state     <= ST_OKAY;
                        HREADYOUT <= 1'b1;
                        wait_cnt  <= '0;
                        if (!pend_write)
                            HRDATA <= mem[pend_idx];
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                ST_ERR1: begin
                    state     <= ST_ERR2;
                    HREADYOUT <= 1'b1;
                    HRESP     <= 1'b1;
                end
                default: begin
                    if (accept) begin
                        if (req_err) begin
                            state      <= ST_ERR1;
                            HREADYOUT  <= 1'b0;
                            HRESP      <= 1'b1;
                            pend_write <= 1'b0;
                            if (!HWRITE)
                                HRDATA <= '0;
                        end else begin
                            pend_write <= HWRITE;
                            pend_idx   <= req_idx;
                            pend_be    <= req_be;
                            HRESP      <= 1'b0;
                            if (req_waits == '0) begin
                                state     <= ST_OKAY;
                                HREADYOUT <= 1'b1;
                                if (!HWRITE)
                                    HRDATA <= rd_word;
                            end else begin
                                state     <= ST_WAIT;
                                HREADYOUT <= 1'b0;
                                wait_cnt  <= req_waits;
                            end
                        end
                    end else begin
                        state      <= ST_IDLE;
                        HREADYOUT  <= 1'b1;
                        HRESP      <= 1'b0;
                        pend_write <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_peripheral_spram_ahb3_ws.sv
// tb/tb_peripheral_spram_ahb3_ws.sv - bench for peripheral_spram_ahb3_ws across wait-state and forwarding variants
module tb_peripheral_spram_ahb3_ws;

    localparam logic [1:0] T_IDLE = 2'b00;
    localparam logic [1:0] T_BUSY = 2'b01;
    localparam logic [1:0] T_NSEQ = 2'b10;
    localparam logic [2:0] SZ_B = 3'd0;
    localparam logic [2:0] SZ_H = 3'd1;
    localparam logic [2:0] SZ_W = 3'd2;

    typedef struct {
        int          id;
        logic [1:0]  trans;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_resp;
        logic        chk_rd;
        logic [31:0] exp_rdata;
        int          exp_waits;
    } vec_t;

    logic        HCLK;
    logic        HRESETn;
    logic [2:0]  hsel;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [1:0]  htrans;
    logic [2:0]  hready_v;
    logic [2:0]  hresp_v;
    logic [31:0] hrdata0, hrdata1, hrdata2;

    logic [1:0]  cur_k;
    logic        ro, rsp;
    logic [31:0] rd;

    vec_t tbl[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    peripheral_spram_ahb3_ws #(.WAIT_STATES(0), .RAW_FORWARD(1)) dut0 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel[0]), .HADDR(haddr), .HWDATA(hwdata),
        .HRDATA(hrdata0), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'b000), .HPROT(4'b0011),
        .HTRANS(htrans), .HMASTLOCK(1'b0), .HREADY(hready_v[0]), .HREADYOUT(hready_v[0]),
        .HRESP(hresp_v[0]));

    peripheral_spram_ahb3_ws #(.WAIT_STATES(3), .RAW_FORWARD(1)) dut1 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel[1]), .HADDR(haddr), .HWDATA(hwdata),
        .HRDATA(hrdata1), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'b000), .HPROT(4'b0011),
        .HTRANS(htrans), .HMASTLOCK(1'b0), .HREADY(hready_v[1]), .HREADYOUT(hready_v[1]),
        .HRESP(hresp_v[1]));

    peripheral_spram_ahb3_ws #(.WAIT_STATES(0), .RAW_FORWARD(0)) dut2 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel[2]), .HADDR(haddr), .HWDATA(hwdata),
        .HRDATA(hrdata2), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'b000), .HPROT(4'b0011),
        .HTRANS(htrans), .HMASTLOCK(1'b0), .HREADY(hready_v[2]), .HREADYOUT(hready_v[2]),
        .HRESP(hresp_v[2]));

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    always_comb begin
        ro  = hready_v[0];
        rsp = hresp_v[0];
        rd  = hrdata0;
        case (cur_k)
            2'd1: begin ro = hready_v[1]; rsp = hresp_v[1]; rd = hrdata1; end
            2'd2: begin ro = hready_v[2]; rsp = hresp_v[2]; rd = hrdata2; end
            default: ;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void add(input logic [1:0] tr, input logic wr, input logic [2:0] sz,
                                input logic [31:0] a, input logic [31:0] wd, input logic er,
                                input logic chk, input logic [31:0] rdx, input int w);
        vec_t v;
        v.id = tbl.size(); v.trans = tr; v.wr = wr; v.size = sz; v.addr = a; v.wdata = wd;
        v.exp_resp = er; v.chk_rd = chk; v.exp_rdata = rdx; v.exp_waits = w;
        tbl.push_back(v);
    endfunction

    // Pipelined master: entered and left just after a rising edge
    task automatic run_vecs(input logic [1:0] k, input int lo, input int hi);
        vec_t sb[$];
        vec_t v;
        int   i     = lo;
        int   waits = 0;
        int   cyc   = 0;
        cur_k = k;
        while ((i <= hi || sb.size() != 0) && cyc < 200) begin
            cyc++;
            hsel = '0;
            if (i <= hi) begin
                hsel[k] = 1'b1;
                htrans  = tbl[i].trans;
                hwrite  = tbl[i].wr;
                hsize   = tbl[i].size;
                haddr   = tbl[i].addr;
            end else begin
                htrans = T_IDLE;
                hwrite = 1'b0;
            end
            if (sb.size() != 0)
                hwdata = sb[0].wdata;
            @(negedge HCLK);
            if (ro) begin
                if (sb.size() != 0) begin
                    v = sb.pop_front();
                    check($sformatf("v%0d_resp", v.id), {31'd0, rsp}, {31'd0, v.exp_resp});
                    check($sformatf("v%0d_waits", v.id), 32'(waits), 32'(v.exp_waits));
                    if (v.chk_rd)
                        check($sformatf("v%0d_rdata", v.id), rd, v.exp_rdata);
                end
                if (i <= hi) begin
                    sb.push_back(tbl[i]);
                    i++;
                    waits = 0;
                end
            end else if (sb.size() != 0) begin
                waits++;
                if (sb[0].exp_resp)
                    check($sformatf("v%0d_err1_resp", sb[0].id), {31'd0, rsp}, 32'd1);
            end
            @(posedge HCLK);
            #1;
        end
        if (i <= hi || sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout dut%0d vectors %0d..%0d: stalled at %0d", k, lo, hi, i);
        end
        hsel   = '0;
        htrans = T_IDLE;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int s0, e0, s1, e1, s2, e2, s3;
        HRESETn = 1'b0; hsel = '0; haddr = '0; hwdata = '0; hwrite = 1'b0;
        hsize = SZ_W; htrans = T_IDLE; cur_k = 2'd0;

        // dut0: zero wait, forwarding
        s0 = tbl.size();
        add(T_NSEQ, 1, SZ_W, 32'h000, 32'h0BADF00D, 0, 0, 32'h0, 0);
        add(T_NSEQ, 1, SZ_W, 32'h010, 32'hDEADBEEF, 0, 0, 32'h0, 0);
        add(T_NSEQ, 0, SZ_W, 32'h010, 32'h0,        0, 1, 32'hDEADBEEF, 0);
        add(T_NSEQ, 1, SZ_W, 32'h020, 32'h11223344, 0, 0, 32'h0, 0);
        add(T_IDLE, 0, SZ_W, 32'h000, 32'h0,        0, 0, 32'h0, 0);
        add(T_NSEQ, 1, SZ_B, 32'h021, 32'h5555AA55, 0, 0, 32'h0, 0);
        add(T_NSEQ, 0, SZ_W, 32'h020, 32'h0,        0, 1, 32'h1122AA44, 0);
        add(T_NSEQ, 1, SZ_H, 32'h022, 32'h77889999, 0, 0, 32'h0, 0);
        add(T_IDLE, 0, SZ_W, 32'h000, 32'h0,        0, 0, 32'h0, 0);
        add(T_NSEQ, 0, SZ_B, 32'h021, 32'h0,        0, 1, 32'h7788AA44, 0);
        add(T_NSEQ, 1, SZ_W, 32'h400, 32'hFFFFFFFF, 1, 0, 32'h0, 1);
        add(T_NSEQ, 0, SZ_W, 32'h000, 32'h0,        0, 1, 32'h0BADF00D, 0);
        add(T_NSEQ, 0, SZ_W, 32'h002, 32'h0,        1, 1, 32'h0, 1);
        add(T_NSEQ, 1, SZ_W, 32'h002, 32'h12345678, 1, 0, 32'h0, 1);
        add(T_NSEQ, 0, 3'd3, 32'h008, 32'h0,        1, 1, 32'h0, 1);
        add(T_BUSY, 0, SZ_W, 32'h000, 32'h0,        0, 0, 32'h0, 0);
        add(T_NSEQ, 1, SZ_W, 32'h3FC, 32'hA5A55A5A, 0, 0, 32'h0, 0);
        add(T_NSEQ, 0, SZ_B, 32'h3FF, 32'h0,        0, 1, 32'hA5A55A5A, 0);
        add(T_NSEQ, 0, SZ_H, 32'h3FD, 32'h0,        1, 1, 32'h0, 1);
        add(T_NSEQ, 0, SZ_W, 32'h000, 32'h0,        0, 1, 32'h0BADF00D, 0);
        e0 = tbl.size() - 1;

        // dut1: three wait states
        s1 = tbl.size();
        add(T_NSEQ, 1, SZ_W, 32'h030, 32'hCAFEF00D, 0, 0, 32'h0, 3);
        add(T_NSEQ, 0, SZ_W, 32'h030, 32'h0,        0, 1, 32'hCAFEF00D, 3);
        add(T_NSEQ, 1, SZ_B, 32'h033, 32'h99FFFFFF, 0, 0, 32'h0, 3);
        add(T_NSEQ, 0, SZ_W, 32'h030, 32'h0,        0, 1, 32'h99FEF00D, 3);
        add(T_NSEQ, 0, SZ_W, 32'h006, 32'h0,        1, 1, 32'h0, 1);
        e1 = tbl.size() - 1;

        // dut2: zero wait, stall instead of forward
        s2 = tbl.size();
        add(T_NSEQ, 1, SZ_W, 32'h020, 32'h11223344, 0, 0, 32'h0, 0);
        add(T_IDLE, 0, SZ_W, 32'h000, 32'h0,        0, 0, 32'h0, 0);
        add(T_NSEQ, 1, SZ_B, 32'h021, 32'h5555AA55, 0, 0, 32'h0, 0);
        add(T_NSEQ, 0, SZ_W, 32'h020, 32'h0,        0, 1, 32'h1122AA44, 1);
        add(T_NSEQ, 0, SZ_W, 32'h020, 32'h0,        0, 1, 32'h1122AA44, 0);
        add(T_NSEQ, 1, SZ_W, 32'h024, 32'h01020304, 0, 0, 32'h0, 0);
        add(T_NSEQ, 0, SZ_W, 32'h020, 32'h0,        0, 1, 32'h1122AA44, 0);
        add(T_NSEQ, 1, SZ_H, 32'h026, 32'hBEEF5555, 0, 0, 32'h0, 0);
        add(T_NSEQ, 0, SZ_B, 32'h024, 32'h0,        0, 1, 32'hBEEF0304, 1);
        e2 = tbl.size() - 1;

        // read-back of dut1 word after an aborted write
        s3 = tbl.size();
        add(T_NSEQ, 0, SZ_W, 32'h030, 32'h0,        0, 1, 32'h99FEF00D, 3);

        repeat (3) @(posedge HCLK);
        #1 HRESETn = 1'b1;
        @(negedge HCLK);
        check("rst_ready", {29'd0, hready_v}, 32'h7);
        check("rst_resp", {29'd0, hresp_v}, 32'h0);
        check("rst_rdata0", hrdata0, 32'h0);
        check("rst_rdata1", hrdata1, 32'h0);
        check("rst_rdata2", hrdata2, 32'h0);
        @(posedge HCLK);
        #1;

        run_vecs(2'd0, s0, e0);
        run_vecs(2'd1, s1, e1);
        run_vecs(2'd2, s2, e2);

        // Reset in the middle of a waited write on dut1
        cur_k = 2'd1;
        hsel = 3'b010; htrans = T_NSEQ; hwrite = 1'b1; hsize = SZ_W; haddr = 32'h030;
        @(negedge HCLK);
        check("abort_accept", {31'd0, ro}, 32'd1);
        @(posedge HCLK);
        #1;
        hsel = '0; htrans = T_IDLE; hwrite = 1'b0; hwdata = 32'h12345678;
        @(negedge HCLK);
        check("abort_in_wait", {31'd0, ro}, 32'd0);
        HRESETn = 1'b0;
        @(posedge HCLK);
        #1 HRESETn = 1'b1;
        @(negedge HCLK);
        check("abort_ready", {31'd0, ro}, 32'd1);
        check("abort_resp", {31'd0, rsp}, 32'd0);
        check("abort_rdata", rd, 32'h0);
        @(posedge HCLK);
        #1;
        run_vecs(2'd1, s3, s3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
